inst_queue: RTL
===============

// Module: inst_queue
// PURPOSE
//  Parametrised instruction queue; successor to the single-entry instruction register.
//  Buffers up to DEPTH fetched instructions between fetch and decode with valid/ready handshakes.
//  Decodes the head entry into the standard 16-bit ISA fields.
//  Returns the NOP encoding whenever it is empty.
// PARAMETERS
//  INST_W    16       instruction width; >=16; fields decode from bits [15:0]
//  DEPTH     4        entries; power of two, >=2
//  NOP_INST  16'h4300 value presented on inst_out when empty/after reset (zero-extended to INST_W)
// PORTS
//  clk       in   1              clock, rising edge
//  resetn    in   1              asynchronous, active-low reset
//  flush     in   1              synchronous discard of all entries (branch/exception)
//  in_valid  in   1              fetch offers inst_in
//  in_ready  out  1              queue accepts inst_in this cycle
//  inst_in   in   INST_W         fetched instruction
//  out_valid out  1              head entry valid
//  out_ready in   1              decode consumes head this cycle
//  inst_out  out  INST_W         head instruction, NOP_INST when empty
//  immed5    out  5              inst_out[10:6]
//  immed8    out  8              inst_out[7:0]
//  immed11   out  11             inst_out[10:0]
//  Rs0/Rd0   out  3 each         inst_out[2:0]
//  Rs1       out  3              inst_out[5:3]
//  Rs2       out  3              inst_out[8:6]
//  Rs3/Rd1   out  3 each         inst_out[10:8]
//  count     out  $clog2(DEPTH+1) entries held
// BEHAVIOUR
//  - Reset (async, resetn=0):
//    - rd_ptr=wr_ptr=0, count=0, out_valid=0, in_ready=1.
//    - inst_out=NOP_INST; fields decode NOP_INST.
//    - Storage array is not reset.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count < DEPTH).
//    - No same-cycle push on full, even with pop.
//  - out_valid = (count != 0).
//  - inst_out = mem[rd_ptr] when valid, else NOP_INST.
//  - All field outputs are combinational slices of inst_out.
//  - Latency: push in cycle N -> on inst_out, out_valid=1 in cycle N+1 (no bypass).
//  - Pointers are log2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
//  - Count update:
//    - push only: +1.
//    - pop only: -1.
//    - push & pop: count unchanged; both pointers advance.
//  - flush (priority over push/pop):
//    - Next edge: rd_ptr=wr_ptr=0, count=0.
//    - Same-cycle push is discarded; same-cycle pop has no effect.
//    - in_ready is still driven from the current count.
//  - Ordering: strict FIFO; no entry is dropped or duplicated except by flush/reset.
//  - Reset asserted mid-stream empties the queue immediately (async); out_valid drops without a clock.
//  - The queue never accepts more than DEPTH entries.
//  - count always equals (wr_ptr - rd_ptr) mod DEPTH, except DEPTH when full.
// CONFIGURATION
//  INSTQ_BYPASS_EN defined:
//    - When count==0 & in_valid & !flush: out_valid=1, inst_out=inst_in combinationally.
//    - If out_ready is also 1, the instruction is consumed and not written (count stays 0).
//    - Otherwise it is written normally.
//  INSTQ_BYPASS_EN undefined:
//    - out_valid depends only on registered count.
//    - There is no in->out combinational path.
// TESTING
//  1. Reset: resetn=0 then 1, no input -> out_valid=0, in_ready=1, inst_out=16'h4300, Rd1=3'd3, count=0.
//  2. Fill/drain: push 16'h1111..16'h4444 with out_ready=0 (DEPTH=4).
//     -> count=4, in_ready=0, push 16'h5555 ignored.
//     -> Then pop 4 -> 1111,2222,3333,4444 in order, then out_valid=0, inst_out=4300.
//  3. Simultaneous: count=2, in_valid=1 & out_ready=1 for 6 cycles.
//     -> count stays 2; output order matches input order.
//     -> Pointers wrap with no loss.
//  4. Flush: count=3 plus in_valid=1 with flush=1.
//     -> Next cycle count=0, out_valid=0; pushed word is absent from later output.
//  5. Decode: push 16'b0101_1010_1100_0111 -> out-side fields:
//     immed5=5'b01011, immed8=8'hC7, Rs0=7, Rs1=0, Rs2=3, Rs3=2.
//  6. Bypass (INSTQ_BYPASS_EN): empty queue, in_valid=1 with 16'hABCD, out_ready=1.
//     -> Same cycle out_valid=1, inst_out=ABCD; next cycle count=0.
//     -> Without the macro: out_valid=0 that cycle, ABCD appears next cycle.

Source files
------------

// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - fetch/decode side bundle for inst_queue (fetch, decode, flush, head fields, count)
interface inst_queue_if #(
  parameter int INST_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] inst_in;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] inst_out;
  logic [4:0]        immed5;
  logic [7:0]        immed8;
  logic [10:0]       immed11;
  logic [2:0]        rs0, rd0, rs1, rs2, rs3, rd1;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, in_valid, inst_in, out_ready,
    input  in_ready, out_valid, inst_out, immed5, immed8, immed11,
    input  rs0, rd0, rs1, rs2, rs3, rd1, count
  );

  modport slave (
    input  flush, in_valid, inst_in, out_ready,
    output in_ready, out_valid, inst_out, immed5, immed8, immed11,
    output rs0, rd0, rs1, rs2, rs3, rd1, count
  );
endinterface

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - DEPTH-entry instruction FIFO between fetch and decode with head-field decode
// Optional same-cycle empty-queue bypass enabled by defining INSTQ_BYPASS_EN.
module inst_queue #(
  parameter int          INST_W   = 16,
  parameter int          DEPTH    = 4,
  parameter logic [15:0] NOP_INST = 16'h4300
) (
  input logic      clk,
  input logic      resetn,
  inst_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [INST_W-1:0] NOP_W = INST_W'(NOP_INST);

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_empty;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [INST_W-1:0] w_head;

  assign w_empty = (r_count == '0);

`ifdef INSTQ_BYPASS_EN
  assign w_bypass = w_empty & q.in_valid & ~q.flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign q.in_ready  = (r_count < CNT_W'(DEPTH));
  assign q.out_valid = ~w_empty | w_bypass;
  assign q.count     = r_count;

  assign w_push = q.in_valid & q.in_ready;
  assign w_pop  = q.out_valid & q.out_ready;

  // A bypassed word that decode takes immediately never touches storage.
  assign w_wr_en = w_push & ~(w_bypass & q.out_ready);
  assign w_rd_en = w_pop & ~w_empty;

  always_comb begin
    w_head = NOP_W;
    if (!w_empty) begin
      w_head = r_mem[r_rd_ptr];
    end else if (w_bypass) begin
      w_head = q.inst_in;
    end
  end

  assign q.inst_out = w_head;
  assign q.immed5   = w_head[10:6];
  assign q.immed8   = w_head[7:0];
  assign q.immed11  = w_head[10:0];
  assign q.rs0      = w_head[2:0];
  assign q.rd0      = w_head[2:0];
  assign q.rs1      = w_head[5:3];
  assign q.rs2      = w_head[8:6];
  assign q.rs3      = w_head[10:8];
  assign q.rd1      = w_head[10:8];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (q.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr_en && !q.flush) begin
      r_mem[r_wr_ptr] <= q.inst_in;
    end
  end
endmodule
